// File: rtl/switch_pkg.sv
// switch_pkg: shared state encoding and default sizing for the switch input path
package switch_pkg;
  typedef enum logic [1:0] {
    LOW    = 2'b00,
    CHK_HI = 2'b01,
    HIGH   = 2'b11,
    CHK_LO = 2'b10
  } state_e;
  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_STABLE_CYCLES = 4;
  localparam int unsigned DEF_CNT_W         = 8;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: plain flop chain bringing an asynchronous level into the clk domain
module sync_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] sync_q;
  // shift raw level through the chain; oldest sample is the synchronised output
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], d};
  assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronise and debounce a raw level, emit clean level plus edge pulses
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic tick,
  output logic out,
  output logic rise,
  output logic fall
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  logic             s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d, fall_q, fall_d;
  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (raw),
    .q     (s)
  );
  // state, counter and event pulses all update on the same edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= LOW;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  // reversal aborts a check every clk; tick only advances the stability count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      LOW: if (s) begin
        state_d = CHK_HI;
        cnt_d   = '0;
      end
      CHK_HI: if (!s) begin
        state_d = LOW;
        cnt_d   = '0;
      end else if (tick) begin
        state_d = (cnt_q == LAST) ? HIGH : CHK_HI;
        rise_d  = (cnt_q == LAST);
        cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      end
      HIGH: if (!s) begin
        state_d = CHK_LO;
        cnt_d   = '0;
      end
      CHK_LO: if (s) begin
        state_d = HIGH;
        cnt_d   = '0;
      end else if (tick) begin
        state_d = (cnt_q == LAST) ? LOW : CHK_LO;
        fall_d  = (cnt_q == LAST);
        cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      end
    endcase
  end
  assign out  = state_q[1];
  assign rise = rise_q;
  assign fall = fall_q;
endmodule
